sib_fifo_sync_ctrl: RTL and testbench
=====================================

// Module: sib_fifo_sync_ctrl
// PURPOSE
//  Single-clock FIFO controller and first-word-fall-through (FWFT) read front end for an
//  external two-port FIFO RAM whose read address is registered (1-cycle read latency).
//  Owns the write/read pointers, full/almost-full/count status and a 2-entry output
//  buffer, giving a valid/ready read interface with 1-word/cycle throughput.
//  Used by the MAC TX/RX datapath and the AHB bridge wherever a buffered stream is needed.
// PARAMETERS
//  DW        64  data width, bits (matches RAM width)
//  AW        4   RAM address width; RAM depth DEPTH = 2**AW
//  AF_MARGIN 2   almost_full asserts when mem_level >= DEPTH-AF_MARGIN (1..DEPTH-1)
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst_n        in   1       synchronous reset, active low
//  flush        in   1       synchronous clear of contents and status (same effect as reset)
//  wr_en        in   1       write request, one word per cycle
//  wr_data      in   DW      write data
//  full         out  1       RAM full; wr_en is ignored while high
//  almost_full  out  1       mem_level >= DEPTH-AF_MARGIN
//  overflow     out  1       sticky: a write was attempted while full
//  count        out  AW+2    words held = mem_level + fetch_pending + ob_cnt (max DEPTH+2)
//  rd_valid     out  1       head word of output buffer valid
//  rd_data      out  DW      head word; stable while rd_valid & !rd_ready
//  rd_ready     in   1       consumer accept; pop = rd_valid & rd_ready
//  mem_we       out  1       RAM write enable
//  mem_waddr    out  AW      RAM write address = wptr[AW-1:0]
//  mem_wdata    out  DW      RAM write data = wr_data
//  mem_raddr    out  AW      RAM read address = rptr[AW-1:0], combinational from rptr
//  mem_rdata    in   DW      RAM read data for address presented the previous cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at edge) or flush=1 at edge: wptr=rptr=0, fetch_pending=0, ob_cnt=0,
//    overflow=0; hence full=0, almost_full=0, count=0, rd_valid=0, mem_we=0. rd_data=0.
//    Both take priority over any wr_en/rd_ready/fetch in the same cycle.
//  - wptr, rptr are AW+1 bits; mem_level = wptr-rptr mod 2**(AW+1); full = (mem_level==DEPTH).
//    Pointers wrap naturally at 2**(AW+1); RAM index uses low AW bits.
//  - Write: mem_we = wr_en & !full (combinational); on the edge wptr increments.
//    wr_en & full: no write, pointer unchanged, overflow set (held until reset/flush).
//  - Fetch: at an edge, fetch fires iff mem_level>0 and (ob_cnt + fetch_pending - pop) < 2,
//    all evaluated before the edge. On fire: rptr increments, fetch_pending<=1; else 0.
//    The RAM captures the old rptr at that edge; mem_rdata is valid the following cycle.
//  - Landing: on the edge after a fetch (fetch_pending=1), mem_rdata is pushed into the output
//    buffer tail. Push and pop in the same cycle are both honoured; buffer never overflows.
//  - Output buffer: 2 entries, in order; rd_valid = (ob_cnt!=0); rd_data = head entry.
//  - Latency: word written into an empty FIFO at edge N -> fetch at edge N+1 -> rd_valid=1
//    in the cycle after edge N+2. With rd_ready held high, one word per cycle thereafter.
//  - Simultaneous write and fetch: both proceed; mem_level unchanged. Write at full with a
//    fetch firing the same edge is still refused (full judged before the edge).
//  - A write into an empty RAM is not fetchable until the following edge (no bypass path).
//  - count, full, almost_full derive from registered state (no combinational path from inputs).
//  - Total capacity DEPTH+2 words; full reflects RAM only.
// TESTING
//  1 Reset: rst_n=0 mid-stream with ob_cnt=2 -> next cycle rd_valid=0, count=0, full=0, overflow=0.
//  2 Latency: DW=64,AW=4; single write 0xA5 at edge N, rd_ready=1 -> rd_valid first high after
//    edge N+2 with rd_data=0xA5, count 1 from edge N, 0 after pop.
//  3 Fill: rd_ready=0, write 0..19 back-to-back -> 18 accepted (16 RAM + 2 buffer), full=1
//    after 18th, almost_full from mem_level 14, writes 18,19 dropped, overflow=1, count=18.
//  4 Stream: wr_en=1 and rd_ready=1 continuously for 100 words -> output 0..99 in order,
//    no gaps after first word, pointers wrap past 32 without loss.
//  5 Backpressure: random rd_ready (50%) during streaming -> rd_data stable while
//    rd_valid & !rd_ready, sequence intact, ob_cnt never exceeds 2.
//  6 Flush: flush=1 with wr_en=1 and pop in the same cycle -> next cycle count=0, rd_valid=0,
//    wptr=rptr=0; subsequent write 0x3C reads back as first word.

Source files
------------

// File: rtl/sib_fifo_sync_ctrl_if.sv
// Write, read, status and RAM-side signals of the synchronous FIFO controller.
// The controller takes the slave modport; the producer/consumer/RAM side takes master.
interface sib_fifo_sync_ctrl_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 4
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic [AW+1:0] count;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  wr_en, wr_data, rd_ready, mem_rdata,
        output full, almost_full, overflow, count, rd_valid, rd_data,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output wr_en, wr_data, rd_ready, mem_rdata,
        input  full, almost_full, overflow, count, rd_valid, rd_data,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/sib_fifo_sync_ctrl.sv
// Single-clock FIFO controller for an external RAM with 1-cycle registered read,
// plus a 2-entry first-word-fall-through output buffer.
module sib_fifo_sync_ctrl #(
    parameter int unsigned DW        = 64,
    parameter int unsigned AW        = 4,
    parameter int unsigned AF_MARGIN = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 flush_i,
    sib_fifo_sync_ctrl_if.slave bus
);
    localparam int unsigned Depth = 2 ** AW;

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   mem_level;
    logic          fetch_pending_q, fetch;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [DW-1:0] ob_q [2];
    logic [DW-1:0] ob_d [2];
    logic          overflow_q, overflow_d;
    logic          full, pop, wr_ok;
    logic [2:0]    ob_need;

    assign mem_level = wptr_q - rptr_q;
    assign full      = (mem_level == (AW+1)'(Depth));
    assign pop       = (ob_cnt_q != 2'd0) & bus.rd_ready;
    assign wr_ok     = bus.wr_en & ~full;

    // Buffer slots already claimed after this cycle's pop; a fetch may only claim a free one.
    assign ob_need = {1'b0, ob_cnt_q} + {2'b00, fetch_pending_q} - {2'b00, pop};
    assign fetch   = (mem_level != '0) && (ob_need < 3'd2);

    assign bus.full        = full;
    assign bus.almost_full = (mem_level >= (AW+1)'(Depth - AF_MARGIN));
    assign bus.overflow    = overflow_q;
    assign bus.count       = (AW+2)'(mem_level) + (AW+2)'(fetch_pending_q) + (AW+2)'(ob_cnt_q);
    assign bus.rd_valid    = (ob_cnt_q != 2'd0);
    assign bus.rd_data     = ob_q[0];
    assign bus.mem_we      = wr_ok;
    assign bus.mem_waddr   = wptr_q[AW-1:0];
    assign bus.mem_wdata   = bus.wr_data;
    assign bus.mem_raddr   = rptr_q[AW-1:0];

    always_comb begin
        wptr_d     = wptr_q + (AW+1)'(wr_ok);
        rptr_d     = rptr_q + (AW+1)'(fetch);
        overflow_d = overflow_q | (bus.wr_en & full);
        ob_d[0]    = ob_q[0];
        ob_d[1]    = ob_q[1];
        ob_cnt_d   = ob_cnt_q;
        if (pop) begin
            ob_d[0]  = ob_q[1];
            ob_cnt_d = ob_cnt_q - 2'd1;
        end
        // Occupancy plus pending fetch never exceeds 2, so the landing slot is 0 or 1.
        if (fetch_pending_q) begin
            ob_d[ob_cnt_d[0]] = bus.mem_rdata;
            ob_cnt_d          = ob_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            fetch_pending_q <= 1'b0;
            ob_cnt_q        <= 2'd0;
            ob_q[0]         <= '0;
            ob_q[1]         <= '0;
            overflow_q      <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            fetch_pending_q <= fetch;
            ob_cnt_q        <= ob_cnt_d;
            ob_q[0]         <= ob_d[0];
            ob_q[1]         <= ob_d[1];
            overflow_q      <= overflow_d;
        end
    end
endmodule

// File: tb/tb_sib_fifo_sync_ctrl.sv
// Directed self-checking bench for sib_fifo_sync_ctrl with a behavioural 1-cycle-latency RAM.
module tb_sib_fifo_sync_ctrl;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    sib_fifo_sync_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    sib_fifo_sync_ctrl #(.DW(DW), .AW(AW), .AF_MARGIN(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [Depth];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_raddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input logic [63:0] first);
        int got;
        got = 0;
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 200 && got < n; c++) begin
            if (bus.rd_valid) begin
                check_eq("drain_data", bus.rd_data, first + 64'(got));
                got++;
            end
            step();
        end
        check_eq("drain_count", 64'(got), 64'(n));
    endtask

    // Writes n words base..base+n-1 at full rate while reading; scoreboards order and count.
    task automatic stream_run(input int n, input logic [63:0] base, input bit rand_ready);
        int            w, r;
        logic          pop, acc, stall;
        logic [DW-1:0] held;
        w = 0;
        r = 0;
        stall = 1'b0;
        held = '0;
        for (int c = 0; c < 2000 && r < n; c++) begin
            check_eq("stream_count", 64'(bus.count), 64'(w - r));
            check_eq("ob_cnt_bound", 64'(dut.ob_cnt_q <= 2'd2), 64'd1);
            if (stall) check_eq("stall_stable", bus.rd_data, held);
            if (!rand_ready && r > 0) check_eq("stream_nogap", 64'(bus.rd_valid), 64'd1);
            bus.rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            pop = bus.rd_valid & bus.rd_ready;
            if (pop) check_eq("stream_data", bus.rd_data, base + 64'(r));
            stall = bus.rd_valid & ~bus.rd_ready;
            held = bus.rd_data;
            bus.wr_en = (w < n);
            bus.wr_data = base + 64'(w);
            acc = bus.wr_en & ~bus.full;
            step();
            if (pop) r++;
            if (acc) w++;
        end
        bus.wr_en = 1'b0;
        check_eq("stream_total", 64'(r), 64'(n));
    endtask

    initial begin
        int k, ml;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.rd_ready = 1'b0;
        step();
        step();
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("rst_full", 64'(bus.full), 64'd0);
        check_eq("rst_afull", 64'(bus.almost_full), 64'd0);
        check_eq("rst_ovf", 64'(bus.overflow), 64'd0);
        check_eq("rst_data", bus.rd_data, 64'd0);
        rst_n = 1'b1;
        step();

        // Latency of a single word through an empty FIFO.
        bus.wr_en = 1'b1;
        bus.wr_data = 64'hA5;
        bus.rd_ready = 1'b1;
        step();
        bus.wr_en = 1'b0;
        check_eq("lat_n_count", 64'(bus.count), 64'd1);
        check_eq("lat_n_valid", 64'(bus.rd_valid), 64'd0);
        step();
        check_eq("lat_n1_count", 64'(bus.count), 64'd1);
        check_eq("lat_n1_valid", 64'(bus.rd_valid), 64'd0);
        step();
        check_eq("lat_n2_valid", 64'(bus.rd_valid), 64'd1);
        check_eq("lat_n2_data", bus.rd_data, 64'hA5);
        check_eq("lat_n2_count", 64'(bus.count), 64'd1);
        step();
        check_eq("lat_pop_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("lat_pop_count", 64'(bus.count), 64'd0);

        // Fill with no reader: two words move to the buffer, sixteen stay in RAM.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 64'(i);
            step();
            k = i + 1;
            ml = (k <= 2) ? 1 : ((k - 2 > 16) ? 16 : k - 2);
            check_eq("fill_count", 64'(bus.count), 64'((k > 18) ? 18 : k));
            check_eq("fill_full", 64'(bus.full), 64'(ml == 16));
            check_eq("fill_afull", 64'(bus.almost_full), 64'(ml >= 14));
            check_eq("fill_ovf", 64'(bus.overflow), 64'(k >= 19));
        end
        bus.wr_en = 1'b0;
        drain(18, 64'd0);
        check_eq("fill_empty", 64'(bus.count), 64'd0);
        check_eq("fill_ovf_sticky", 64'(bus.overflow), 64'd1);

        // Reset mid-stream with the output buffer full.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 64'(100 + i);
            step();
        end
        bus.wr_en = 1'b0;
        step();
        step();
        step();
        check_eq("pre_rst_count", 64'(bus.count), 64'd4);
        check_eq("pre_rst_obcnt", 64'(dut.ob_cnt_q), 64'd2);
        rst_n = 1'b0;
        bus.wr_en = 1'b1;
        bus.rd_ready = 1'b1;
        step();
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_ready = 1'b0;
        check_eq("mrst_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("mrst_count", 64'(bus.count), 64'd0);
        check_eq("mrst_full", 64'(bus.full), 64'd0);
        check_eq("mrst_ovf", 64'(bus.overflow), 64'd0);
        check_eq("mrst_data", bus.rd_data, 64'd0);
        step();

        stream_run(100, 64'd0, 1'b0);
        step();
        step();
        check_eq("stream_empty", 64'(bus.count), 64'd0);
        stream_run(60, 64'd1000, 1'b1);
        step();
        step();
        check_eq("bp_empty", 64'(bus.count), 64'd0);

        // Flush together with a write and a pop.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 64'(16'h200 + i);
            step();
        end
        bus.wr_en = 1'b0;
        step();
        step();
        check_eq("pre_flush_valid", 64'(bus.rd_valid), 64'd1);
        flush = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 64'h77;
        bus.rd_ready = 1'b1;
        step();
        flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_ready = 1'b0;
        check_eq("flush_count", 64'(bus.count), 64'd0);
        check_eq("flush_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("flush_waddr", 64'(bus.mem_waddr), 64'd0);
        check_eq("flush_raddr", 64'(bus.mem_raddr), 64'd0);
        bus.wr_en = 1'b1;
        bus.wr_data = 64'h3C;
        step();
        bus.wr_en = 1'b0;
        drain(1, 64'h3C);
        check_eq("flush_after_empty", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
